// File: rtl/cpu_pkg.sv
// Shared multicycle-CPU definitions: opcodes, FSM state encoding, datapath mux encodings
// and the packed control-word payload driven by the control FSM.
package cpu_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned SEL_W   = 2;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REXEC  = 4'd6,
      S_RWB    = 4'd7,
      S_BEQEX  = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [SEL_W-1:0] ALUOP_ADD  = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB  = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNC = 2'b10;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

   typedef struct packed {
      logic             pc_write;
      logic             pc_write_cond;
      logic             ior_d;
      logic             mem_read;
      logic             mem_write;
      logic             ir_write;
      logic             mem_to_reg;
      logic             reg_write;
      logic             reg_dst;
      logic             alu_src_a;
      logic [SEL_W-1:0] pc_source;
      logic [SEL_W-1:0] alu_op;
      logic [SEL_W-1:0] alu_src_b;
   } ctrl_t;

endpackage

// File: rtl/control_out_dec.sv
// Moore decode of the control FSM state into the multicycle datapath control word.
module control_out_dec
   import cpu_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl           = '0;
      ctrl.pc_source = PCSRC_ALU;
      ctrl.alu_op    = ALUOP_ADD;
      ctrl.alu_src_b = SRCB_REG;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.pc_write  = 1'b1;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
         S_MEMADR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.ior_d    = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.ior_d     = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_REXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNC;
         end
         S_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDIWB: ctrl.reg_write = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multicycle CPU control FSM with retired-instruction counter.
// Define CONTROL_FSM_ADDI_EN to decode ADDI (otherwise 001000 is flagged illegal).
module control_fsm
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             ALUSrcA,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ALUSrcB,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   state_t cur, nxt;
   ctrl_t  dec, ctrl;
   logic   is_sw;
   logic   legal;
   logic   retire;
   logic   unused_func;

   // func only steers the ALU control downstream
   assign unused_func = ^func;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur   <= S_FETCH;
         is_sw <= 1'b0;
      end else begin
         cur <= nxt;
         if (cur == S_DECODE) is_sw <= (opcode == OP_SW);
      end
   end

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
`ifdef CONTROL_FSM_ADDI_EN
         OP_ADDI: legal = 1'b1;
`endif
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH: nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_REXEC;
               OP_BEQ:       nxt = S_BEQEX;
               OP_J:         nxt = S_JUMP;
`ifdef CONTROL_FSM_ADDI_EN
               OP_ADDI:      nxt = S_ADDIEX;
`endif
               default:      nxt = S_FETCH;
            endcase
         end
         // LW/SW choice was captured while in DECODE
         S_MEMADR: nxt = is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:  nxt = S_MEMWB;
         S_REXEC:  nxt = S_RWB;
         S_ADDIEX: nxt = S_ADDIWB;
         default:  nxt = S_FETCH;
      endcase
   end

   always_comb begin
      retire = 1'b0;
      case (cur)
         S_MEMWB, S_MEMWR, S_RWB, S_BEQEX, S_JUMP, S_ADDIWB: retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        instr_count <= '0;
      else if (retire) instr_count <= instr_count + CNT_W'(1);
   end

   control_out_dec u_dec (
      .state (cur),
      .ctrl  (dec)
   );

   // Outputs are held low combinationally for the whole reset window
   always_comb begin
      ctrl       = '0;
      illegal_op = 1'b0;
      if (rst) begin
         ctrl       = dec;
         illegal_op = (cur == S_DECODE) && !legal;
      end
   end

   assign state       = cur;
   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.ior_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign PCSource    = ctrl.pc_source;
   assign ALUOp       = ctrl.alu_op;
   assign ALUSrcB     = ctrl.alu_src_b;

endmodule
